// File: rtl/piano_pkg.sv
// Shared types and constants for the piano voice allocator.
// Holds the voice lifecycle enum and the default key/note widths.
package piano_pkg;

  localparam int NKEYS = 8;
  localparam int KW    = $clog2(NKEYS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ON      = 2'd1,
    RELEASE = 2'd2
  } voice_state_t;

endpackage

// File: rtl/voice_slot.sv
// One divider voice: lifecycle state, note, saturating age and release timer.
// Ports: clk, rst, alloc strobe, new_note, key_lvl (level of the held note) -> state, note, age.
module voice_slot #(
  parameter int KW         = piano_pkg::KW,
  parameter int REL_CYCLES = 1024,
  parameter int AGEW       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc,
  input  logic [KW-1:0]          new_note,
  input  logic                   key_lvl,
  output piano_pkg::voice_state_t state,
  output logic [KW-1:0]          note,
  output logic [AGEW-1:0]        age
);
  import piano_pkg::*;

  localparam int RW = (REL_CYCLES > 1) ? $clog2(REL_CYCLES) : 1;
  localparam logic [RW-1:0]   REL_LOAD = RW'(REL_CYCLES - 1);
  localparam logic [AGEW-1:0] AGE_MAX  = '1;

  voice_state_t    st_q, st_d;
  logic [KW-1:0]   note_q, note_d;
  logic [AGEW-1:0] age_q, age_d;
  logic [RW-1:0]   rel_q, rel_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      note_q <= '0;
      age_q  <= '0;
      rel_q  <= '0;
    end else begin
      st_q   <= st_d;
      note_q <= note_d;
      age_q  <= age_d;
      rel_q  <= rel_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    note_d = note_q;
    age_d  = age_q;
    rel_d  = rel_q;
    if (st_q != IDLE && age_q != AGE_MAX)
      age_d = age_q + 1'b1;
    // Allocation overrides release entry and release expiry.
    if (alloc) begin
      st_d   = ON;
      note_d = new_note;
      age_d  = '0;
      rel_d  = '0;
    end else begin
      unique case (st_q)
        ON: begin
          if (!key_lvl) begin
            st_d  = RELEASE;
            rel_d = REL_LOAD;
          end
        end
        RELEASE: begin
          if (rel_q == '0)
            st_d = IDLE;
          else
            rel_d = rel_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = st_q;
  assign note  = note_q;
  assign age   = age_q;

endmodule

// File: rtl/voice_alloc.sv
// Voice allocator: maps key presses onto NVOICES shared divider voices.
// Ports: clk, rst, keys -> voice_en, voice_note (KW bits per voice), voice_new, steal.
module voice_alloc #(
  parameter int NKEYS      = piano_pkg::NKEYS,
  parameter int NVOICES    = 4,
  parameter int KW         = piano_pkg::KW,
  parameter int REL_CYCLES = 1024,
  parameter int AGEW       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NKEYS-1:0]      keys,
  output logic [NVOICES-1:0]    voice_en,
  output logic [NVOICES*KW-1:0] voice_note,
  output logic [NVOICES-1:0]    voice_new,
  output logic                  steal
);
  import piano_pkg::*;

  localparam int VW = (NVOICES > 1) ? $clog2(NVOICES) : 1;

  logic [NKEYS-1:0]   keys_q, pend_q, pend_d;
  logic [NVOICES-1:0] new_q, alloc;
  logic               steal_q, steal_d;

  voice_state_t    st  [NVOICES];
  logic [KW-1:0]   nt  [NVOICES];
  logic [AGEW-1:0] age [NVOICES];
  logic [NVOICES-1:0] key_lvl;

  logic          svc_vld;
  logic [KW-1:0] svc_key;

  logic          hit_vld, idle_vld, rel_vld, on_vld;
  logic [VW-1:0] hit_idx, idle_idx, rel_idx, on_idx, tgt;
  logic [AGEW-1:0] rel_age, on_age;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keys_q  <= '0;
      pend_q  <= '0;
      new_q   <= '0;
      steal_q <= 1'b0;
    end else begin
      keys_q  <= keys;
      pend_q  <= pend_d;
      new_q   <= alloc;
      steal_q <= steal_d;
    end
  end

  // Lowest pending key wins the single service slot.
  always_comb begin
    svc_vld = 1'b0;
    svc_key = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        svc_vld = 1'b1;
        svc_key = KW'(i);
      end
    end
  end

  // Candidate voices per priority class; strict '>' keeps lowest index on ties.
  always_comb begin
    hit_vld  = 1'b0;
    hit_idx  = '0;
    idle_vld = 1'b0;
    idle_idx = '0;
    rel_vld  = 1'b0;
    rel_idx  = '0;
    rel_age  = '0;
    on_vld   = 1'b0;
    on_idx   = '0;
    on_age   = '0;
    for (int v = NVOICES - 1; v >= 0; v--) begin
      if (st[v] != IDLE && nt[v] == svc_key) begin
        hit_vld = 1'b1;
        hit_idx = VW'(v);
      end
      if (st[v] == IDLE) begin
        idle_vld = 1'b1;
        idle_idx = VW'(v);
      end
    end
    for (int v = 0; v < NVOICES; v++) begin
      if (st[v] == RELEASE && (!rel_vld || age[v] > rel_age)) begin
        rel_vld = 1'b1;
        rel_idx = VW'(v);
        rel_age = age[v];
      end
      if (st[v] == ON && (!on_vld || age[v] > on_age)) begin
        on_vld = 1'b1;
        on_idx = VW'(v);
        on_age = age[v];
      end
    end
  end

  always_comb begin
    tgt     = '0;
    alloc   = '0;
    steal_d = 1'b0;
    if (hit_vld) begin
      tgt = hit_idx;
    end else if (idle_vld) begin
      tgt = idle_idx;
    end else if (rel_vld) begin
      tgt     = rel_idx;
      steal_d = svc_vld;
    end else begin
      tgt     = on_idx;
      steal_d = svc_vld && on_vld;
    end
    if (svc_vld)
      alloc[tgt] = 1'b1;
  end

  // A press is dropped if the key goes low before it is serviced.
  always_comb begin
    pend_d = (pend_q | (keys & ~keys_q)) & keys;
    if (svc_vld)
      pend_d[svc_key] = 1'b0;
  end

  for (genvar g = 0; g < NVOICES; g++) begin : g_voice
    assign key_lvl[g] = keys[nt[g]];

    voice_slot #(
      .KW         (KW),
      .REL_CYCLES (REL_CYCLES),
      .AGEW       (AGEW)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .alloc    (alloc[g]),
      .new_note (svc_key),
      .key_lvl  (key_lvl[g]),
      .state    (st[g]),
      .note     (nt[g]),
      .age      (age[g])
    );

    assign voice_en[g]            = (st[g] != IDLE);
    assign voice_note[g*KW +: KW] = nt[g];
  end

  assign voice_new = new_q;
  assign steal     = steal_q;

endmodule

// File: tb/tb_voice_alloc.sv
// Bench for voice_alloc: directed scenarios plus random key traffic.
// A reference model using allocation times and release deadlines predicts every output.
module tb_voice_alloc;

  localparam int NK  = 8;
  localparam int NV  = 4;
  localparam int REL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  keys = '0;
  logic [3:0]  voice_en, voice_new;
  logic [11:0] voice_note;
  logic        steal;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  voice_alloc #(
    .NKEYS      (NK),
    .NVOICES    (NV),
    .KW         (3),
    .REL_CYCLES (REL),
    .AGEW       (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .keys       (keys),
    .voice_en   (voice_en),
    .voice_note (voice_note),
    .voice_new  (voice_new),
    .steal      (steal)
  );

  // model: 0 idle, 1 on, 2 release
  int       m_st    [NV];
  int       m_note  [NV];
  int       m_birth [NV];
  int       m_end   [NV];
  bit       m_pend  [NK];
  bit       m_kq    [NK];
  bit [3:0] m_new;
  bit       m_steal;
  int       m_n;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_st[v]    = 0;
      m_note[v]  = 0;
      m_birth[v] = 0;
      m_end[v]   = 0;
    end
    for (int i = 0; i < NK; i++) begin
      m_pend[i] = 0;
      m_kq[i]   = 0;
    end
    m_new   = '0;
    m_steal = 0;
    m_n     = 0;
  endtask

  task automatic model_edge(input logic [7:0] k);
    int svc, tgt;
    bit stl;
    svc = -1;
    tgt = -1;
    stl = 0;
    for (int i = NK - 1; i >= 0; i--)
      if (m_pend[i]) svc = i;
    if (svc >= 0) begin
      for (int v = NV - 1; v >= 0; v--)
        if (m_st[v] != 0 && m_note[v] == svc) tgt = v;
      if (tgt < 0)
        for (int v = NV - 1; v >= 0; v--)
          if (m_st[v] == 0) tgt = v;
      if (tgt < 0) begin
        for (int v = 0; v < NV; v++)
          if (m_st[v] == 2 && (tgt < 0 || m_birth[v] < m_birth[tgt])) tgt = v;
        stl = (tgt >= 0);
      end
      if (tgt < 0) begin
        for (int v = 0; v < NV; v++)
          if (m_st[v] == 1 && (tgt < 0 || m_birth[v] < m_birth[tgt])) tgt = v;
        stl = 1;
      end
    end
    m_new = '0;
    for (int v = 0; v < NV; v++) begin
      if (v == tgt) begin
        m_st[v]    = 1;
        m_note[v]  = svc;
        m_birth[v] = m_n;
        m_new[v]   = 1'b1;
      end else if (m_st[v] == 1 && !k[m_note[v]]) begin
        m_st[v]  = 2;
        m_end[v] = m_n + REL;
      end else if (m_st[v] == 2 && m_n == m_end[v]) begin
        m_st[v] = 0;
      end
    end
    for (int i = 0; i < NK; i++) begin
      m_pend[i] = (m_pend[i] || (k[i] && !m_kq[i])) && k[i] && (i != svc);
      m_kq[i]   = k[i];
    end
    m_steal = stl;
    m_n++;
  endtask

  task automatic compare();
    logic [3:0]  en;
    logic [11:0] nn;
    int          tmp;
    for (int v = 0; v < NV; v++) begin
      en[v] = (m_st[v] != 0);
      tmp = m_note[v];
      nn[v*3 +: 3] = tmp[2:0];
    end
    check("voice_en", voice_en, en);
    check("voice_note", voice_note, nn);
    check("voice_new", voice_new, m_new);
    check("steal", steal, m_steal);
  endtask

  task automatic tick(input logic [7:0] k);
    keys = k;
    @(posedge clk);
    model_edge(k);
    @(negedge clk);
    compare();
  endtask

  task automatic hold_all(input logic [7:0] k);
    repeat (6) tick(k);
  endtask

  initial begin
    logic [7:0] k;

    #1 rst = 1'b1;
    model_reset();
    #2;
    compare();
    @(negedge clk);
    rst = 1'b0;

    // single press, 2-edge latency
    tick(8'h04);
    tick(8'h04);
    check("t1_en", voice_en, 4'b0001);
    check("t1_note0", voice_note[2:0], 3'd2);
    check("t1_new", voice_new, 4'b0001);
    check("t1_steal", steal, 1'b0);
    tick(8'h04);
    check("t1_new_once", voice_new, 4'b0000);

    // release hold time
    tick(8'h00);
    repeat (3) tick(8'h00);
    check("rel_hold", voice_en[0], 1'b1);
    tick(8'h00);
    check("rel_done", voice_en[0], 1'b0);
    check("rel_note", voice_note[2:0], 3'd2);

    // two keys in one cycle: one service per edge
    tick(8'h05);
    tick(8'h05);
    check("t2_en_a", voice_en, 4'b0001);
    check("t2_note0", voice_note[2:0], 3'd0);
    tick(8'h05);
    check("t2_en_b", voice_en, 4'b0011);
    check("t2_note1", voice_note[5:3], 3'd2);
    hold_all(8'h00);

    // all ON: oldest ON voice is stolen
    tick(8'h01); tick(8'h03); tick(8'h07); tick(8'h0F);
    tick(8'h0F); tick(8'h0F);
    check("t3_full", voice_en, 4'b1111);
    tick(8'h2F); tick(8'h2F);
    check("t3_new", voice_new, 4'b0001);
    check("t3_steal", steal, 1'b1);
    check("t3_note0", voice_note[2:0], 3'd5);
    hold_all(8'h00);

    // a RELEASE voice is preferred over ON voices
    tick(8'h01); tick(8'h03); tick(8'h07); tick(8'h0F);
    tick(8'h0F); tick(8'h0F);
    tick(8'h0B);
    tick(8'h2B); tick(8'h2B);
    check("t3r_new", voice_new, 4'b0100);
    check("t3r_steal", steal, 1'b1);
    check("t3r_note2", voice_note[8:6], 3'd5);

    // re-press while releasing: retrigger same voice
    tick(8'h23);
    tick(8'h2B); tick(8'h2B);
    check("t4_new", voice_new, 4'b1000);
    check("t4_steal", steal, 1'b0);
    check("t4_note3", voice_note[11:9], 3'd3);
    check("t4_en", voice_en, 4'b1111);

    // asynchronous reset mid-release
    tick(8'h00); tick(8'h00);
    #2 rst = 1'b1;
    #1;
    check("rst_en", voice_en, 4'b0000);
    check("rst_new", voice_new, 4'b0000);
    check("rst_steal", steal, 1'b0);
    model_reset();
    keys = 8'h01;
    #1 rst = 1'b0;
    tick(8'h01);
    check("t5_wait", voice_en, 4'b0000);
    tick(8'h01);
    check("t5_en", voice_en, 4'b0001);
    check("t5_note0", voice_note[2:0], 3'd0);

    // random traffic
    repeat (4000) begin
      k = keys;
      for (int b = 0; b < NK; b++)
        if ($urandom_range(0, 5) == 0) k[b] = ~k[b];
      tick(k);
      if ($urandom_range(0, 99) == 0) repeat (8) tick(8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
